// File: rtl/fetch_unit_if.sv
// Bus bundle for the instruction fetch front end.
// The master modport is the fetch unit itself: it drives the instruction
// memory request and the decode-side head; the slave modport is the
// environment (memory plus decode/control stage).
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr, imem_rmask, dec_instr, dec_pc, dec_valid,
        input  imem_rdata, imem_resp, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, imem_rmask, dec_instr, dec_pc, dec_valid,
        output imem_rdata, imem_resp, dec_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Issues one word read at a time from a sequential PC, buffers the returned
// words with their PC in a small in-order queue and presents the queue head
// to decode with a valid/ready handshake. A redirect flushes everything
// buffered and in flight; a response owed to a flushed request is swallowed
// in the DROP state.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode in the cycle it arrives when the queue is empty. Without it all
// decode outputs come from registered queue storage.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          QDEPTH   = 4
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   pc_mem    [QDEPTH];
    logic [31:0]   instr_mem [QDEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          head_valid;
    logic          resp_accept;
    logic          pop;
    logic          push;
    logic          room;
    logic          issue;
    logic          bypass_hit;
    logic          bypass_take;
    logic [CW-1:0] count_after_pop;
    logic [31:0]   redirect_target;
    logic          unused_pc_lsbs;

    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
    assign unused_pc_lsbs  = ^bus.redirect_pc[1:0];

    // Queue bookkeeping: what gets pushed, popped and whether a new request fits.
    always_comb begin
        head_valid      = (count_q != '0);
        resp_accept     = (state_q == WAIT) & bus.imem_resp & ~bus.redirect;
        pop             = head_valid & bus.dec_ready & ~bus.redirect;
        count_after_pop = count_q - CW'(pop);
        room            = (count_after_pop < QDEPTH_C);
`ifdef FETCH_BYPASS_EN
        bypass_hit      = resp_accept & ~head_valid;
`else
        bypass_hit      = 1'b0;
`endif
        bypass_take     = bypass_hit & bus.dec_ready;
        push            = resp_accept & ~bypass_take;
    end

    // Next-state logic; a request only goes out from ISSUE when there is room
    // for its eventual response and no redirect is pending this cycle.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ISSUE: begin
                if (!bus.redirect && room && rst_n) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_resp) begin
                    state_d = ISSUE;
                end else if (bus.redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.imem_resp) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // Memory request and decode-side outputs.
    always_comb begin
        bus.imem_addr  = fetch_pc_q;
        bus.imem_rmask = issue ? 4'hf : 4'h0;
`ifdef FETCH_BYPASS_EN
        bus.dec_valid  = head_valid | bypass_hit;
        bus.dec_instr  = bypass_hit ? bus.imem_rdata : instr_mem[rd_ptr_q];
        bus.dec_pc     = bypass_hit ? fetch_pc_q     : pc_mem[rd_ptr_q];
`else
        bus.dec_valid  = head_valid;
        bus.dec_instr  = instr_mem[rd_ptr_q];
        bus.dec_pc     = pc_mem[rd_ptr_q];
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC: redirect wins, otherwise advance once per accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc_q <= redirect_target;
        end else if (resp_accept) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Queue storage: each entry holds the returned word and the PC it came from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// A memory model answers each request after a programmable delay with the
// inverted address; a reference model tracks the expected fetch PC and the
// ordered list of instructions decode should see.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;
    localparam int          QDEPTH   = 4;
`ifdef FETCH_BYPASS_EN
    localparam int          FIRST_LAT = 1;
    localparam int          MIN_DELIVERED = 15;
`else
    localparam int          FIRST_LAT = 2;
    localparam int          MIN_DELIVERED = 14;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;

    logic [31:0] model_q[$];
    logic [31:0] model_pc;
    logic        pending;
    logic        pend_live;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          mem_delay;

    int          cyc;
    int          first_req_cyc;
    int          first_val_cyc;
    logic [31:0] first_req_addr;
    logic [31:0] first_val_pc;
    int          req_count;
    int          delivered;
    logic [3:0]  last_rmask;
    logic [31:0] last_addr;
    logic        last_valid;
    logic        seen_zero;

    task automatic model_reset();
        model_q.delete();
        model_pc      = RESET_PC;
        pending       = 1'b0;
        pend_live     = 1'b0;
        pend_wait     = 0;
        first_req_cyc = -1;
        first_val_cyc = -1;
        req_count     = 0;
        delivered     = 0;
        cyc           = 0;
    endtask

    task automatic drive_idle();
        bus.dec_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_resp   = 1'b0;
        bus.imem_rdata  = 32'h0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs 1 time
    // unit later, advance the model and the memory, then move to the next
    // falling edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        resp_now;
        logic        bypass_hit;
        logic        exp_valid;
        logic        pop;
        logic        exp_issue;
        logic [31:0] head;
        int          occ;

        resp_now        = pending && (pend_wait == 1);
        bus.dec_ready   = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.imem_resp   = resp_now;
        bus.imem_rdata  = resp_now ? ~pend_addr : $urandom();
        #1;

        bypass_hit = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass_hit = resp_now && pend_live && !redir && (model_q.size() == 0);
`endif
        exp_valid = (model_q.size() != 0) || bypass_hit;

        checks++;
        if (bus.dec_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, bus.dec_valid, exp_valid);
        end
        if (exp_valid) begin
            head = (model_q.size() != 0) ? model_q[0] : pend_addr;
            checks++;
            if (bus.dec_pc !== head) begin
                errors++;
                $display("[TB] FAIL dec_pc cyc=%0d got=%h exp=%h", cyc, bus.dec_pc, head);
            end
            checks++;
            if (bus.dec_instr !== ~head) begin
                errors++;
                $display("[TB] FAIL dec_instr cyc=%0d got=%h exp=%h", cyc, bus.dec_instr, ~head);
            end
        end

        pop       = exp_valid && rdy && !redir;
        occ       = model_q.size() - ((pop && model_q.size() != 0) ? 1 : 0);
        exp_issue = !redir && !pending && (occ < QDEPTH);

        checks++;
        if (bus.imem_rmask !== (exp_issue ? 4'hf : 4'h0)) begin
            errors++;
            $display("[TB] FAIL imem_rmask cyc=%0d got=%h exp=%h", cyc, bus.imem_rmask,
                     exp_issue ? 4'hf : 4'h0);
        end
        checks++;
        if (bus.imem_addr !== model_pc) begin
            errors++;
            $display("[TB] FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, model_pc);
        end

        last_rmask = bus.imem_rmask;
        last_addr  = bus.imem_addr;
        last_valid = bus.dec_valid;
        if (bus.dec_valid === 1'b1 && first_val_cyc < 0) begin
            first_val_cyc = cyc;
            first_val_pc  = bus.dec_pc;
        end
        if (bus.dec_valid === 1'b1 && rdy && !redir) begin
            delivered++;
        end

        // Advance the reference model.
        if (pop && model_q.size() != 0) begin
            void'(model_q.pop_front());
        end
        if (resp_now) begin
            pending = 1'b0;
            if (pend_live && !redir) begin
                if (!(bypass_hit && rdy)) begin
                    model_q.push_back(pend_addr);
                end
                model_pc = model_pc + 32'd4;
            end
        end else if (pending) begin
            pend_wait--;
        end
        if (redir) begin
            model_q.delete();
            model_pc  = {rpc[31:2], 2'b00};
            pend_live = 1'b0;
        end

        // Memory accepts a new request.
        if (bus.imem_rmask == 4'hf) begin
            checks++;
            if (pending !== 1'b0) begin
                errors++;
                $display("[TB] FAIL outstanding cyc=%0d got=%b exp=%b", cyc, pending, 1'b0);
            end
            if (bus.imem_addr == 32'h0) seen_zero = 1'b1;
            if (first_req_cyc < 0) begin
                first_req_cyc  = cyc;
                first_req_addr = bus.imem_addr;
            end
            req_count++;
            pending   = 1'b1;
            pend_live = 1'b1;
            pend_addr = bus.imem_addr;
            pend_wait = mem_delay;
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic reset_dut();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.imem_rmask !== 4'h0) begin
            errors++;
            $display("[TB] FAIL %s_rmask got=%h exp=%h", tag, bus.imem_rmask, 4'h0);
        end
        checks++;
        if (bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL %s_addr got=%h exp=%h", tag, bus.imem_addr, RESET_PC);
        end
        checks++;
        if (bus.dec_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_valid got=%b exp=%b", tag, bus.dec_valid, 1'b0);
        end
        checks++;
        if (bus.dec_instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL %s_instr got=%h exp=%h", tag, bus.dec_instr, 32'h0);
        end
        checks++;
        if (bus.dec_pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL %s_pc got=%h exp=%h", tag, bus.dec_pc, 32'h0);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        bus.dec_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        $display("[TB] test_stream");
        reset_dut();
        mem_delay = 1;
        repeat (30) cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if ((first_val_cyc - first_req_cyc) !== FIRST_LAT) begin
            errors++;
            $display("[TB] FAIL first_latency got=%0d exp=%0d", first_val_cyc - first_req_cyc, FIRST_LAT);
        end
        checks++;
        if (delivered < MIN_DELIVERED) begin
            errors++;
            $display("[TB] FAIL throughput got=%0d exp>=%0d", delivered, MIN_DELIVERED);
        end
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        reset_dut();
        mem_delay = 1;
        repeat (20) cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (req_count !== QDEPTH) begin
            errors++;
            $display("[TB] FAIL stall_requests got=%0d exp=%0d", req_count, QDEPTH);
        end
        checks++;
        if (last_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_valid got=%b exp=%b", last_valid, 1'b1);
        end
        first_req_cyc = -1;
        repeat (12) cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (first_req_addr !== RESET_PC + 32'h10) begin
            errors++;
            $display("[TB] FAIL resume_addr got=%h exp=%h", first_req_addr, RESET_PC + 32'h10);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        $display("[TB] test_redirect_wait");
        reset_dut();
        mem_delay = 4;
        n = 0;
        while (!pending && n < 20) begin
            cycle(1'b1, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL redir_wait_timeout got=%b exp=%b", pending, 1'b1);
        end
        cycle(1'b1, 1'b1, 32'h00001003);
        first_val_cyc = -1;
        n = 0;
        while (first_val_cyc < 0 && n < 30) begin
            cycle(1'b1, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (first_val_pc !== 32'h00001000 || first_val_cyc < 0) begin
            errors++;
            $display("[TB] FAIL redir_first_pc got=%h exp=%h", first_val_pc, 32'h00001000);
        end
    endtask

    task automatic test_redirect_resp();
        int          n;
        logic [31:0] tgt;
        $display("[TB] test_redirect_resp");
        reset_dut();
        mem_delay = 1;
        n = 0;
        while (!(model_q.size() == 2 && pending && pend_wait == 1) && n < 20) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (model_q.size() !== 2) begin
            errors++;
            $display("[TB] FAIL half_full_timeout got=%0d exp=%0d", model_q.size(), 2);
        end
        tgt = $urandom();
        cycle(1'b0, 1'b1, tgt);
        cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (last_rmask !== 4'hf) begin
            errors++;
            $display("[TB] FAIL redir_resp_rmask got=%h exp=%h", last_rmask, 4'hf);
        end
        checks++;
        if (last_addr !== {tgt[31:2], 2'b00}) begin
            errors++;
            $display("[TB] FAIL redir_resp_addr got=%h exp=%h", last_addr, {tgt[31:2], 2'b00});
        end
        checks++;
        if (last_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_resp_valid got=%b exp=%b", last_valid, 1'b0);
        end
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        mem_delay = 1;
        cycle(1'b1, 1'b1, 32'hfffffffe);
        seen_zero = 1'b0;
        repeat (12) cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (seen_zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_addr0 got=%b exp=%b", seen_zero, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        int n;
        $display("[TB] test_async_reset");
        reset_dut();
        mem_delay = 3;
        n = 0;
        while (!(model_q.size() == 3 && pending) && n < 40) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (model_q.size() !== 3) begin
            errors++;
            $display("[TB] FAIL three_queued_timeout got=%0d exp=%0d", model_q.size(), 3);
        end
        drive_idle();
        bus.dec_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if (first_req_addr !== RESET_PC || first_req_cyc < 0) begin
            errors++;
            $display("[TB] FAIL restart_addr got=%h exp=%h", first_req_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic rdy;
        logic redir;
        $display("[TB] test_random");
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if (!pending) mem_delay = $urandom_range(1, 3);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 29) == 0);
            cycle(rdy, redir, $urandom());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_delay = 1;
        seen_zero = 1'b0;
        drive_idle();
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
